// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning the architectural
// HI/LO registers. MULT/MULTU/DIV/DIVU take WIDTH+2 cycles from the edge that
// accepts start until HI/LO hold the result. MTHI/MTLO writes land only while idle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Operation context captured when start is accepted.
  logic            is_div;     // op[1]: divide family
  logic            neg_prod;   // product / quotient sign (a xor b sign, signed ops only)
  logic            neg_rem;    // remainder sign (dividend sign, signed ops only)
  logic            div_zero;   // divisor was zero
  logic [WIDTH-1:0] a_raw;     // raw dividend, returned in HI on divide by zero

  // addend: multiplicand (mult) or divisor (div).
  // scan:   multiplier (mult) or dividend (div), consumed MSB first.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   scan;
  logic [2*WIDTH-1:0] acc;     // product, or {remainder, quotient}

  // Magnitudes and signs of the incoming operands.
  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand conditioning for the capture in IDLE.
  always_comb begin
    sgn_op = ~op[0];
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  // One radix-2 iteration: shift-add for multiply, restoring step for divide.
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    rem_sh   = {acc[2*WIDTH-1:WIDTH], scan[WIDTH-1]};
    trial    = rem_sh - {1'b0, addend};
    if (is_div) begin
      // Trial subtraction: a clear borrow bit means the divisor fits.
      if (!trial[WIDTH])
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      // MSB-first shift-add: acc = 2*acc + bit*multiplicand.
      acc_next = {acc[2*WIDTH-2:0], 1'b0}
               + (scan[WIDTH-1] ? {{WIDTH{1'b0}}, addend} : {2*WIDTH{1'b0}});
    end
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Final sign fix-up of the magnitude result.
  always_comb begin
    prod_fix = neg_prod ? -acc : acc;
    quo_fix  = neg_prod ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath registers and HI/LO with registered busy/done.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_prod <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      addend   <= '0;
      scan     <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      if (flush && state != IDLE) begin
        // Abort: HI/LO untouched, no done pulse.
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
            if (start && !flush) begin
              state    <= CALC;
              busy     <= 1'b1;
              cnt      <= '0;
              is_div   <= op[1];
              neg_prod <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= (b == '0);
              a_raw    <= a;
              addend   <= op[1] ? b_mag : a_mag;
              scan     <= op[1] ? a_mag : b_mag;
              acc      <= '0;
            end
          end
          CALC: begin
            acc  <= acc_next;
            scan <= {scan[WIDTH-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit at WIDTH=32
// and WIDTH=8 against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=32 instance signals.
  logic        start32, flush32, wh32, wl32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  // WIDTH=8 instance signals.
  logic        start8, flush8, wh8, wl8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .wr_hi(wh32), .wr_lo(wl32), .wdata(wd32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .wr_hi(wh8), .wr_lo(wl8), .wdata(wd8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Observation mux so one task can check either instance.
  logic        sel8;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;
  always_comb begin
    if (sel8) begin
      o_busy = busy8;  o_done = done8;
      o_hi   = {24'd0, hi8}; o_lo = {24'd0, lo8};
    end else begin
      o_busy = busy32; o_done = done32;
      o_hi   = hi32;   o_lo   = lo32;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics from integer arithmetic at width w.
  function automatic void ref_muldiv(input int w, input logic [1:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r_hi, output logic [31:0] r_lo);
    longint mask, sa, sb, q, r;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (!op[0]) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    if (!op[1]) begin
      p    = 64'(sa * sb);
      r_hi = 32'((p >> w) & 64'(mask));
      r_lo = 32'(p & 64'(mask));
    end else if (sb == 0) begin
      r_hi = 32'(longint'(a) & mask);
      r_lo = 32'(mask);
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      r_hi = 32'(r & mask);
      r_lo = 32'(q & mask);
    end
  endfunction

  task automatic drive_start(input bit w8, input logic s, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = s; op32 = op; a32 = a; b32 = b;
    end
  endtask

  // Issue one operation from an idle cycle (called #1 after a rising edge) and
  // check latency, busy length and result. Returns in the done cycle, so a
  // following call issues its start back-to-back. restart_at > 0 raises start
  // again so that the edge with that number samples it.
  task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int restart_at, input string tag);
    int w, busy_n, done_at;
    w = w8 ? 8 : 32;
    sel8 = w8;
    drive_start(w8, 1'b1, op, a, b);
    @(posedge clk); #1;
    busy_n  = 0;
    done_at = -1;
    for (int c = 1; c <= w + 4; c++) begin
      drive_start(w8, c == restart_at, 2'b01, 32'd3, 32'd3);
      if (o_busy) busy_n++;
      if (o_done) begin
        done_at = c;
        break;
      end
      @(posedge clk); #1;
    end
    drive_start(w8, 1'b0, op, a, b);
    check({tag, "_done_cycle"}, 64'(done_at), 64'(w + 2));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(w + 1));
    check({tag, "_busy_in_done"}, 64'(o_busy), 64'd0);
    check({tag, "_hi"}, 64'(o_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(o_lo), 64'(exp_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic [1:0]  rop;
    int          done_n;

    rst = 1'b1; sel8 = 1'b0;
    start32 = 0; flush32 = 0; wh32 = 0; wl32 = 0; op32 = 0; a32 = 0; b32 = 0; wd32 = 0;
    start8  = 0; flush8  = 0; wh8  = 0; wl8  = 0; op8  = 0; a8  = 0; b8  = 0; wd8  = 0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state of both instances.
    sel8 = 1'b0; #0;
    check("rst32_hi", 64'(o_hi), 64'd0);
    check("rst32_lo", 64'(o_lo), 64'd0);
    check("rst32_busy", 64'(o_busy), 64'd0);
    check("rst32_done", 64'(o_done), 64'd0);
    sel8 = 1'b1; #0;
    check("rst8_hi", 64'(o_hi), 64'd0);
    check("rst8_busy", 64'(o_busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed WIDTH=32 vectors, issued back-to-back.
    run_op(0, 2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, "mult_neg3x5");
    run_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, "multu_max");
    run_op(0, 2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        -1, "divu_100_7");
    run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, "div_neg7_2");
    run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, -1, "div_ovf");
    run_op(0, 2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, -1, "divu_by0");
    run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, "div_by0_neg");
    // Second start at edge 5 must be ignored.
    run_op(0, 2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        5,  "divu_restart");
    @(posedge clk); #1;
    check("done_single_pulse", 64'(o_done), 64'd0);

    // MTHI preload, then an operation that is flushed.
    wh32 = 1'b1; wd32 = 32'h0000_AAAA;
    @(posedge clk); #1;
    wh32 = 1'b0;
    check("mthi_visible", 64'(o_hi), 64'h0000_AAAA);
    drive_start(0, 1'b1, 2'b11, 32'd100, 32'd7);
    wl32 = 1'b1; wd32 = 32'h0000_5555;
    @(posedge clk); #1;                     // edge 0
    drive_start(0, 1'b0, 2'b11, 32'd100, 32'd7);
    wl32 = 1'b0;
    check("mtlo_with_start", 64'(o_lo), 64'h0000_5555);
    check("busy_after_start", 64'(o_busy), 64'd1);
    for (int e = 1; e <= 10; e++) begin
      drive_start(0, e == 5, 2'b01, 32'd3, 32'd3);
      wh32 = (e == 3);
      wd32 = 32'h0000_DEAD;
      @(posedge clk); #1;                   // edge e
    end
    drive_start(0, 1'b0, 2'b01, 32'd3, 32'd3);
    wh32 = 1'b0;
    check("busy_before_flush", 64'(o_busy), 64'd1);
    flush32 = 1'b1;
    @(posedge clk); #1;                     // edge 11
    flush32 = 1'b0;
    check("busy_after_flush", 64'(o_busy), 64'd0);
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) done_n++;
      @(posedge clk); #1;
    end
    check("flush_no_done", 64'(done_n), 64'd0);
    check("flush_hi_kept", 64'(o_hi), 64'h0000_AAAA);
    check("flush_lo_kept", 64'(o_lo), 64'h0000_5555);

    // Flush and start in the same idle cycle: flush wins.
    drive_start(0, 1'b1, 2'b00, 32'd5, 32'd5);
    flush32 = 1'b1;
    @(posedge clk); #1;
    drive_start(0, 1'b0, 2'b00, 32'd5, 32'd5);
    flush32 = 1'b0;
    check("flush_beats_start", 64'(o_busy), 64'd0);

    // Reset in the middle of an operation.
    drive_start(0, 1'b1, 2'b01, 32'd9, 32'd9);
    @(posedge clk); #1;
    drive_start(0, 1'b0, 2'b01, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_hi", 64'(o_hi), 64'd0);
    check("midrst_lo", 64'(o_lo), 64'd0);
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) done_n++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 64'(done_n), 64'd0);

    // Randomized WIDTH=32 operations with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      ref_muldiv(32, rop, ra, rb, eh, el);
      run_op(0, rop, ra, rb, eh, el, -1, "rnd32");
    end
    @(posedge clk); #1;

    // WIDTH=8 instance.
    run_op(1, 2'b11, 32'd200, 32'd9,  32'd2,  32'd22, -1, "divu8_200_9");
    run_op(1, 2'b10, 32'h80,  32'hFF, 32'd0,  32'h80, -1, "div8_ovf");
    run_op(1, 2'b00, 32'h80,  32'h80, 32'h40, 32'h00, -1, "mult8_min_sq");
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      ref_muldiv(8, rop, ra, rb, eh, el);
      run_op(1, rop, ra, rb, eh, el, -1, "rnd8");
    end
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle 64-bit multiplier and the separate HI/LO register file in the EX stage. It executes MULT/MULTU/DIV/DIVU over a fixed WIDTH+2 cycles and holds the pipeline via `busy`. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- `WIDTH`, default 32: operand width; must be ≥ 2. HI/LO are each WIDTH bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request an operation; accepted only while idle.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  in  WIDTH  rs operand: multiplicand or dividend.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `flush`  in  1  abort the in-flight operation (exception or eret in MEM).
- `wr_hi`  in  1  MTHI write strobe.
- `wr_lo`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high whenever the state is not IDLE; the ID stage stalls any HI/LO-touching instruction while it is high.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register (remainder, or upper product half).
- `lo`  out  WIDTH  LO register (quotient, or lower product half).

## Operation
- States are IDLE, CALC and FIX. A counter of width clog2(WIDTH+1) counts iterations.
- **IDLE → CALC**
  - Transition occurs when `start` is high and `flush` is low.
  - Captures `op`.
  - For signed ops, captures |a| and |b|. For unsigned ops, captures a and b raw.
  - Captures the product sign (a xor b sign bits) and the remainder sign (a sign bit).
  - Clears the 2·WIDTH-bit accumulator.
- **CALC**
  - Performs one radix-2 step per cycle, for WIDTH cycles.
  - Multiply uses shift-add.
  - Divide uses restoring division: shift the remainder left, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - After the WIDTH-th step, the state goes to FIX.
- **FIX**
  - Product: negates the 2·WIDTH result if the product sign is set, giving {HI, LO}.
  - Quotient: negated if the signs differ.
  - Remainder: negated if the dividend is negative.
  - Writes HI/LO, pulses `done`, and returns to IDLE.
- **Divide by zero**: LO = all ones and HI = a (raw operand), for both DIV and DIVU. No exception is raised.
- **Signed overflow** (DIV of the most-negative value by −1): LO = most-negative value, HI = 0. This is the natural result of magnitude arithmetic modulo 2^WIDTH.
- **`start` while busy**: ignored.
- **`flush`**
  - Forces IDLE on the next edge from any state.
  - HI/LO are unchanged and no `done` pulse is produced.
  - If `flush` and `start` arrive in the same cycle, `flush` wins and `start` is dropped.
- **`wr_hi` / `wr_lo`**
  - Honoured only in IDLE and ignored while busy.
  - If `start` arrives in the same IDLE cycle, the write still lands. The later FIX overwrites it.
- **Reads**: `hi`/`lo` are direct register outputs. Forwarding is the bypass unit's job.

## Timing
- **Reset values**: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0. Reset mid-operation discards the operation with no `done`.
- **Latency, numbering edges from the edge that samples `start`** (edge 0):
  - Edges 1..WIDTH perform the steps.
  - Edge WIDTH+1 performs FIX: HI/LO are updated and `done` = 1 for the following cycle.
- **`busy`**
  - High for exactly WIDTH+1 cycles, from after edge 0 through edge WIDTH+1.
  - Low in the cycle where `done` is high, so a back-to-back `start` may be sampled at the same edge that ends the `done` cycle.
- **Flush latency**: `busy` falls one edge after `flush` is sampled.
- **MTHI/MTLO**: the new value is visible on `hi`/`lo` one cycle after the write edge.

## Test plan
- **MULT**, WIDTH=32, a=0xFFFFFFFD (−3), b=5 → at edge 33 HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done` pulses once; `busy` is high for 33 cycles.
- **MULTU**, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **DIVU 100/7** → LO=14, HI=2.
- **DIV** a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Corner cases**:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234.
- **Flush, start-while-busy and MTHI**:
  - Preload HI=0xAAAA via `wr_hi`.
  - Start DIVU, then assert `start` again at edge 5 → the second start is ignored.
  - Assert `flush` at edge 10 → `busy` falls at edge 11, no `done` pulse, HI=0xAAAA retained.
  - Repeat with WIDTH=8: DIVU 200/9 → LO=22, HI=2 at edge 9.
